regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 16-bit MIPS register file (8 × 16-bit, 3-bit address) between two writeback requesters: the ALU result path (A) and the load/memory path (B). Each requester uses a valid/ready handshake. One accepted request is registered and driven onto the register-file write port on the following cycle. A per-register pending mask is exported for the hazard unit.

---
 rtl/mips16_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/wb_rr_arb2.sv | 55 +++++
 rtl/regfile_wb_arbiter.sv | 68 ++++++
 tb/tb_regfile_wb_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mips16_pkg.sv
// Shared constants and types for the 16-bit MIPS datapath.
// Holds the register-file geometry and the writeback requester ids.
package mips16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 2 ** ADDR_W;

  // Writeback requester id; the value doubles as the bit index into the
  // request/grant vectors of the arbiter.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage : mips16_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: two valid/ready requesters (ALU and load path)
// sharing the register-file write port.
interface regfile_wb_arbiter_if;
  import mips16_pkg::*;

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  // Requester side: drives requests, observes grants.
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  // Arbiter side: observes requests, drives grants.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );

endinterface : regfile_wb_arbiter_if

// File: rtl/wb_rr_arb2.sv
// Two-input writeback arbiter. Bit 0 is the ALU requester, bit 1 the load
// requester. With REGFILE_ARB_RR_EN defined, contention is resolved by a
// round-robin pointer that moves to the losing side; otherwise the ALU
// always wins and no pointer register exists. Grants are forced low while
// reset is asserted.
module wb_rr_arb2
  import mips16_pkg::*;
(
`ifdef REGFILE_ARB_RR_EN
  input  logic       clk,
`endif
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef REGFILE_ARB_RR_EN
  req_id_t prio;

  // Combinational grant: a lone requester wins, contention goes to prio.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    gnt = 2'b00;
    if (rst) begin
      if (req[REQ_ALU] && req[REQ_MEM]) begin
        gnt[prio] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer moves to the loser on contention only; single grants leave it.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      prio <= REQ_ALU;
    end else if (req[REQ_ALU] && req[REQ_MEM]) begin
      prio <= (prio == REQ_ALU) ? REQ_MEM : REQ_ALU;
    end
  end
`else
  // Fixed priority: the ALU path always wins contention.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      gnt[REQ_ALU] = req[REQ_ALU];
      gnt[REQ_MEM] = req[REQ_MEM] & ~req[REQ_ALU];
    end
  end
`endif

endmodule : wb_rr_arb2

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter for the 16-bit MIPS core.
// Grants one of two writeback requesters per cycle, registers the accepted
// address/data into a write stage that drives the register file on the next
// cycle, and decodes a one-hot pending mask for the hazard unit.
// Build option: define REGFILE_ARB_RR_EN for round-robin arbitration;
// the default build uses fixed ALU-first priority.
module regfile_wb_arbiter
  import mips16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 write_EN,
  output logic [ADDR_W-1:0]    reg_write_add,
  output logic [DATA_W-1:0]    reg_write_data,
  output logic [NREG-1:0]      wb_pending
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       acc_a;
  logic       acc_b;

  assign req[REQ_ALU] = bus.a_valid;
  assign req[REQ_MEM] = bus.b_valid;

  wb_rr_arb2 u_arb (
`ifdef REGFILE_ARB_RR_EN
    .clk (clk),
`endif
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign bus.a_ready = gnt[REQ_ALU];
  assign bus.b_ready = gnt[REQ_MEM];

  assign acc_a = bus.a_valid & gnt[REQ_ALU];
  assign acc_b = bus.b_valid & gnt[REQ_MEM];

  // Write stage: capture the accepted request; hold addr/data when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_EN       <= 1'b0;
      reg_write_add  <= '0;
      reg_write_data <= '0;
    end else begin
      write_EN <= acc_a | acc_b;
      if (acc_a) begin
        reg_write_add  <= bus.a_addr;
        reg_write_data <= bus.a_data;
      end else if (acc_b) begin
        reg_write_add  <= bus.b_addr;
        reg_write_data <= bus.b_data;
      end
    end
  end

  // Pending mask: one-hot of the register being written this cycle.
  always_comb begin
    wb_pending = '0;
    if (write_EN) begin
      wb_pending[reg_write_add] = 1'b1;
    end
  end

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. Expectations follow the build:
// round-robin when REGFILE_ARB_RR_EN is defined, fixed priority otherwise.
module tb_regfile_wb_arbiter;
  import mips16_pkg::*;

`ifdef REGFILE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] bd;
    logic              ea;
    logic              eb;
  } vec_t;

  typedef struct {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk;
  logic              rst;
  logic              write_EN;
  logic [ADDR_W-1:0] reg_write_add;
  logic [DATA_W-1:0] reg_write_data;
  logic [NREG-1:0]   wb_pending;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .write_EN       (write_EN),
    .reg_write_add  (reg_write_add),
    .reg_write_data (reg_write_data),
    .wb_pending     (wb_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  wr_t               sb_q[$];
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] model_rf [NREG];
  vec_t              vecs [13];

  // Register-file model fed from the DUT write port.
  always @(posedge clk) begin
    if (write_EN) model_rf[reg_write_add] <= reg_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NREG-1:0] onehot(input logic en, input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] p;
    p = '0;
    if (en) p[a] = 1'b1;
    return p;
  endfunction

  // One cycle: called in the low clock phase. Drives requests, checks grants,
  // queues the expected write, then checks the write stage after the edge.
  task automatic step(input vec_t v, input string tag);
    wr_t e;
    wr_t got;
    bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
    bus.b_valid = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
    #1;
    check({tag, " a_ready"}, 32'(bus.a_ready), 32'(v.ea));
    check({tag, " b_ready"}, 32'(bus.b_ready), 32'(v.eb));
    if (v.ea) begin
      exp_addr = v.aa; exp_data = v.ad;
    end else if (v.eb) begin
      exp_addr = v.ba; exp_data = v.bd;
    end
    e.en = v.ea | v.eb; e.addr = exp_addr; e.data = exp_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, " write_EN"}, 32'(write_EN), 32'(got.en));
      check({tag, " reg_write_add"}, 32'(reg_write_add), 32'(got.addr));
      check({tag, " reg_write_data"}, 32'(reg_write_data), 32'(got.data));
      check({tag, " wb_pending"}, 32'(wb_pending), 32'(onehot(got.en, got.addr)));
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREG; i++) model_rf[i] = '0;
    exp_addr = '0;
    exp_data = '0;

    //        av  aa    ad        bv  ba    bd        ea   eb
    vecs[0]  = '{1, 3'd1, 16'h5342, 1, 3'd3, 16'haae3, 1'b1, 1'b0};
    vecs[1]  = '{1, 3'd1, 16'h5342, 1, 3'd3, 16'haae3, !RR,  RR};
    vecs[2]  = '{1, 3'd1, 16'h5342, 1, 3'd3, 16'haae3, 1'b1, 1'b0};
    vecs[3]  = '{1, 3'd1, 16'h5342, 1, 3'd3, 16'haae3, !RR,  RR};
    vecs[4]  = '{1, 3'd2, 16'ha334, 0, 3'd0, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{0, 3'd7, 16'hdead, 0, 3'd6, 16'hbeef, 1'b0, 1'b0};
    vecs[6]  = '{0, 3'd0, 16'h0000, 1, 3'd5, 16'h0777, 1'b0, 1'b1};
    vecs[7]  = '{1, 3'd0, 16'hfee5, 1, 3'd0, 16'h1234, 1'b1, 1'b0};
    vecs[8]  = '{0, 3'd0, 16'h0000, 1, 3'd0, 16'h1234, 1'b0, 1'b1};
    vecs[9]  = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{1, 3'd6, 16'h1111, 1, 3'd7, 16'h2222, !RR,  RR};
    vecs[11] = '{1, 3'd6, 16'h1111, 1, 3'd7, 16'h2222, 1'b1, 1'b0};
    vecs[12] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1'b0, 1'b0};

    // Reset held with both requesters valid: no grants, idle write port.
    rst = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 16'h5342;
    bus.b_valid = 1'b1; bus.b_addr = 3'd3; bus.b_data = 16'haae3;
    repeat (2) @(negedge clk);
    #1;
    check("reset a_ready", 32'(bus.a_ready), 32'd0);
    check("reset b_ready", 32'(bus.b_ready), 32'd0);
    check("reset write_EN", 32'(write_EN), 32'd0);
    check("reset wb_pending", 32'(wb_pending), 32'd0);
    check("reset reg_write_add", 32'(reg_write_add), 32'd0);
    check("reset reg_write_data", 32'(reg_write_data), 32'd0);

    // Release in the low phase; the first arbitration edge follows.
    rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
      if (i == 9) check("same-address final r0", 32'(model_rf[0]), 32'h1234);
    end

    // Mid-operation reset: accept B, then reset before the write lands.
    step('{0, 3'd0, 16'h0000, 1, 3'd4, 16'h0bb5, 1'b0, 1'b1}, "midrst accept");
    bus.b_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst write_EN async clear", 32'(write_EN), 32'd0);
    check("midrst wb_pending", 32'(wb_pending), 32'd0);
    check("midrst reg_write_data", 32'(reg_write_data), 32'd0);
    exp_addr = '0;
    exp_data = '0;
    @(posedge clk);
    @(negedge clk);
    check("midrst no write of r4", 32'(model_rf[4]), 32'd0);

    // After release prio is back on A: contention goes to A.
    rst = 1'b1;
    step('{1, 3'd2, 16'h0aaa, 1, 3'd4, 16'h0bb5, 1'b1, 1'b0}, "post-reset");
    step('{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1'b0, 1'b0}, "post-reset idle");
    check("post-reset r4 untouched", 32'(model_rf[4]), 32'd0);
    check("post-reset r2 written", 32'(model_rf[2]), 32'h0aaa);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
